// File: rtl/regfile_pkg.sv
// Shared defaults and the holding-buffer entry type for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned DefXlen = 32;
  localparam int unsigned DefAw   = 5;
  localparam int unsigned DefNreq = 3;

  typedef struct packed {
    logic                valid;
    logic [DefAw-1:0]    addr;
    logic [DefXlen-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr_i wins.
module rr_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  int unsigned j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges NREQ single-entry writeback buffers onto one registered register-file write port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned XLEN = DefXlen,
  parameter int unsigned AW   = DefAw
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][AW-1:0]    req_addr,
  input  logic [NREQ-1:0][XLEN-1:0]  req_data,
  output logic                       reg_wr,
  output logic [AW-1:0]              waddr,
  output logic [XLEN-1:0]            wdata,
  output logic [2**AW-1:0]           pending
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_entry_t       buf_q [NREQ];
  wb_entry_t       buf_d [NREQ];
  wb_entry_t       gnt_entry;
  logic [NREQ-1:0] full;
  logic [NREQ-1:0] gnt;
  logic [IdxW-1:0] gnt_idx;
  logic            gnt_any;
  logic [IdxW-1:0] rr_q, rr_d;
  logic            reg_wr_q;
  logic [AW-1:0]   waddr_q;
  logic [XLEN-1:0] wdata_q;

  always_comb begin
    for (int i = 0; i < NREQ; i++) full[i] = buf_q[i].valid;
  end

  rr_arbiter #(
    .N    (NREQ),
    .IdxW (IdxW)
  ) u_rr (
    .req_i (full),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // A granted buffer drains this cycle, so it can take a new entry without a bubble.
  assign req_ready = ~full | gnt;

  always_comb begin
    gnt_entry = '0;
    for (int i = 0; i < NREQ; i++) begin
      buf_d[i] = buf_q[i];
      if (gnt[i]) begin
        gnt_entry = buf_q[i];
        buf_d[i]  = '0;
      end
      // Writes to x0 complete the handshake but are dropped.
      if (req_valid[i] && req_ready[i] && (req_addr[i] != '0)) begin
        buf_d[i] = '{valid: 1'b1, addr: req_addr[i], data: req_data[i]};
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_any) rr_d = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) buf_q[i] <= '0;
      rr_q     <= '0;
      reg_wr_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) buf_q[i] <= buf_d[i];
      rr_q     <= rr_d;
      reg_wr_q <= gnt_any;
      if (gnt_any) begin
        waddr_q <= gnt_entry.addr;
        wdata_q <= gnt_entry.data;
      end
    end
  end

  // The buffers are the only record of accepted-but-unissued writes.
  always_comb begin
    pending = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (buf_q[i].valid) pending[buf_q[i].addr] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign reg_wr = reg_wr_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a per-address count model.
module tb_regfile_wb_arbiter;

  localparam int N    = 3;
  localparam int AW   = 5;
  localparam int XLEN = 32;
  localparam int NR   = 32;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [N-1:0]             req_valid = '0;
  logic [N-1:0]             req_ready;
  logic [N-1:0][AW-1:0]     req_addr = '0;
  logic [N-1:0][XLEN-1:0]   req_data = '0;
  logic                     reg_wr;
  logic [AW-1:0]            waddr;
  logic [XLEN-1:0]          wdata;
  logic [NR-1:0]            pending;

  int checks   = 0;
  int failures = 0;

  // Reference model: one slot per requester, a rotating priority start, and a per-register
  // count of outstanding writes.
  bit              m_valid [N];
  logic [AW-1:0]   m_addr  [N];
  logic [XLEN-1:0] m_data  [N];
  int              m_ptr;
  logic            m_wr;
  logic [AW-1:0]   m_waddr;
  logic [XLEN-1:0] m_wdata;
  int              cnt [NR];
  logic [N-1:0]    exp_ready, obs_ready;

  regfile_wb_arbiter #(.NREQ(N), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .reg_wr    (reg_wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [NR-1:0] exp_pend();
    logic [NR-1:0] r;
    r = '0;
    for (int k = 1; k < NR; k++) r[k] = (cnt[k] > 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_addr[i] = '0; m_data[i] = '0;
    end
    for (int k = 0; k < NR; k++) cnt[k] = 0;
    m_ptr = 0; m_wr = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0][AW-1:0] a,
                       input logic [N-1:0][XLEN-1:0] d);
    int mg;
    req_valid = v; req_addr = a; req_data = d;
    mg = -1;
    for (int k = 0; k < N; k++) begin
      if (mg < 0 && m_valid[(m_ptr + k) % N]) mg = (m_ptr + k) % N;
    end
    for (int i = 0; i < N; i++) exp_ready[i] = !m_valid[i] || (mg == i);
    #1 obs_ready = req_ready;
    @(posedge clk);
    if (mg >= 0) begin
      m_wr = 1'b1; m_waddr = m_addr[mg]; m_wdata = m_data[mg];
      cnt[int'(m_addr[mg])]--;
      m_valid[mg] = 0;
      m_ptr = (mg + 1) % N;
    end else begin
      m_wr = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (v[i] && exp_ready[i] && a[i] != '0) begin
        m_valid[i] = 1; m_addr[i] = a[i]; m_data[i] = d[i];
        cnt[int'(a[i])]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (reg_wr !== 1'b0) begin failures++; $display("FAIL reset_reg_wr got=%b want=0", reg_wr); end
    checks++; if (waddr !== '0) begin failures++; $display("FAIL reset_waddr got=%0d want=0", waddr); end
    checks++; if (wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h want=0", wdata); end
    checks++; if (pending !== '0) begin failures++; $display("FAIL reset_pending got=%h want=0", pending); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL reset_ready got=%b want=111", req_ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [N-1:0][AW-1:0]   a;
    logic [N-1:0][XLEN-1:0] d;
    a = '0; d = '0; a[0] = 5'd5; d[0] = 32'hDEADBEEF;
    cycle(3'b001, a, d);
    checks++; if (obs_ready !== 3'b111) begin failures++; $display("FAIL single_ready got=%b want=111", obs_ready); end
    checks++; if (reg_wr !== 1'b0) begin failures++; $display("FAIL single_e0_wr got=%b want=0", reg_wr); end
    checks++; if (pending !== 32'h20) begin failures++; $display("FAIL single_e0_pend got=%h want=00000020", pending); end
    cycle(3'b000, a, d);
    checks++; if (reg_wr !== 1'b1) begin failures++; $display("FAIL single_e1_wr got=%b want=1", reg_wr); end
    checks++; if (waddr !== 5'd5) begin failures++; $display("FAIL single_e1_waddr got=%0d want=5", waddr); end
    checks++; if (wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_e1_wdata got=%h want=deadbeef", wdata); end
    checks++; if (pending !== '0) begin failures++; $display("FAIL single_e1_pend got=%h want=0", pending); end
    cycle(3'b000, a, d);
    checks++; if (reg_wr !== 1'b0) begin failures++; $display("FAIL single_e2_wr got=%b want=0", reg_wr); end
  endtask

  task automatic test_contention();
    logic [N-1:0][AW-1:0]   a;
    logic [N-1:0][XLEN-1:0] d;
    do_reset();
    // Second round only issues 1,2,3 again if the pointer wrapped back to 0.
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = AW'(i + 1); d[i] = 32'hA000_0000 + 32'(round * 16 + i);
      end
      cycle(3'b111, a, d);
      for (int r = 0; r < N; r++) begin
        cycle(3'b000, a, d);
        checks++;
        if (reg_wr !== 1'b1 || waddr !== AW'(r + 1) || wdata !== d[r]) begin
          failures++;
          $display("FAIL contention_order round=%0d slot=%0d got wr=%b addr=%0d data=%h want wr=1 addr=%0d data=%h",
                   round, r, reg_wr, waddr, wdata, r + 1, d[r]);
        end
      end
      cycle(3'b000, a, d);
      checks++; if (reg_wr !== 1'b0) begin failures++; $display("FAIL contention_idle got=%b want=0", reg_wr); end
    end
  endtask

  task automatic test_x0_drop();
    logic [N-1:0][AW-1:0]   a;
    logic [N-1:0][XLEN-1:0] d;
    a = '0; d = '0; d[1] = 32'h1234;
    cycle(3'b010, a, d);
    checks++; if (obs_ready[1] !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b want=1", obs_ready[1]); end
    checks++; if (pending !== '0) begin failures++; $display("FAIL x0_pend got=%h want=0", pending); end
    cycle(3'b000, a, d);
    checks++; if (reg_wr !== 1'b0) begin failures++; $display("FAIL x0_wr got=%b want=0", reg_wr); end
    checks++; if (pending !== '0) begin failures++; $display("FAIL x0_pend2 got=%h want=0", pending); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0][AW-1:0]   a;
    logic [N-1:0][XLEN-1:0] d;
    logic [AW-1:0]   pa;
    logic [XLEN-1:0] pd;
    a = '0; d = '0; pa = '0; pd = '0;
    for (int c = 0; c < 10; c++) begin
      a[2] = AW'($urandom_range(1, NR - 1)); d[2] = $urandom;
      cycle(3'b100, a, d);
      checks++; if (obs_ready[2] !== 1'b1) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b want=1", c, obs_ready[2]); end
      if (c > 0) begin
        checks++;
        if (reg_wr !== 1'b1 || waddr !== pa || wdata !== pd) begin
          failures++;
          $display("FAIL b2b_write cyc=%0d got wr=%b addr=%0d data=%h want wr=1 addr=%0d data=%h",
                   c, reg_wr, waddr, wdata, pa, pd);
        end
      end
      pa = a[2]; pd = d[2];
    end
    cycle(3'b000, a, d);
    checks++; if (waddr !== pa || wdata !== pd) begin failures++; $display("FAIL b2b_last got addr=%0d data=%h want addr=%0d data=%h", waddr, wdata, pa, pd); end
    cycle(3'b000, a, d);
  endtask

  task automatic test_same_addr();
    logic [N-1:0][AW-1:0]   a;
    logic [N-1:0][XLEN-1:0] d;
    do_reset();
    a = '0; d = '0; a[0] = 5'd7; a[1] = 5'd7; d[0] = 32'h1111_AAAA; d[1] = 32'h2222_BBBB;
    cycle(3'b011, a, d);
    checks++; if (pending[7] !== 1'b1) begin failures++; $display("FAIL same_e0_pend got=%b want=1", pending[7]); end
    cycle(3'b000, a, d);
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h1111_AAAA) begin failures++; $display("FAIL same_first got wr=%b addr=%0d data=%h want wr=1 addr=7 data=1111aaaa", reg_wr, waddr, wdata); end
    checks++; if (pending[7] !== 1'b1) begin failures++; $display("FAIL same_e1_pend got=%b want=1", pending[7]); end
    cycle(3'b000, a, d);
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h2222_BBBB) begin failures++; $display("FAIL same_second got wr=%b addr=%0d data=%h want wr=1 addr=7 data=2222bbbb", reg_wr, waddr, wdata); end
    checks++; if (pending[7] !== 1'b0) begin failures++; $display("FAIL same_e2_pend got=%b want=0", pending[7]); end
  endtask

  task automatic test_random();
    logic [N-1:0]           v;
    logic [N-1:0][AW-1:0]   a;
    logic [N-1:0][XLEN-1:0] d;
    for (int c = 0; c < 400; c++) begin
      v = N'($urandom);
      for (int i = 0; i < N; i++) begin
        a[i] = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 8));
        d[i] = $urandom;
      end
      cycle(v, a, d);
      checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready); end
      checks++; if (reg_wr !== m_wr) begin failures++; $display("FAIL rand_wr cyc=%0d got=%b want=%b", c, reg_wr, m_wr); end
      checks++; if (waddr !== m_waddr || wdata !== m_wdata) begin failures++; $display("FAIL rand_wport cyc=%0d got addr=%0d data=%h want addr=%0d data=%h", c, waddr, wdata, m_waddr, m_wdata); end
      checks++; if (pending !== exp_pend()) begin failures++; $display("FAIL rand_pend cyc=%0d got=%h want=%h", c, pending, exp_pend()); end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0][AW-1:0]   a;
    logic [N-1:0][XLEN-1:0] d;
    do_reset();
    for (int i = 0; i < N; i++) begin a[i] = AW'(i + 4); d[i] = $urandom; end
    cycle(3'b111, a, d);
    cycle(3'b000, a, d);
    #2 rst = 1'b1;
    #1;
    checks++; if (reg_wr !== 1'b0 || waddr !== '0 || wdata !== '0) begin failures++; $display("FAIL rstmid_outs got wr=%b addr=%0d data=%h want all zero", reg_wr, waddr, wdata); end
    checks++; if (pending !== '0) begin failures++; $display("FAIL rstmid_pend got=%h want=0", pending); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL rstmid_ready got=%b want=111", req_ready); end
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      cycle(3'b000, a, d);
      checks++; if (reg_wr !== 1'b0 || pending !== '0) begin failures++; $display("FAIL rstmid_nowrite cyc=%0d got wr=%b pend=%h want wr=0 pend=0", c, reg_wr, pending); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_x0_drop();
    test_back_to_back();
    test_same_addr();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
